// File: rtl/lpif_txrx_pkg.sv
// Shared definitions for the LPIF TX/RX datapath.
//   - Field widths of one LPIF flit and the packed flit word carried through buffers.
//   - LPIF link state encodings as seen on the state field.
//   - Saturating 16-bit accumulate helper for event counters.
package lpif_txrx_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned PROTID_W = 2;
  localparam int unsigned DATA_W   = 256;
  localparam int unsigned CRC_W    = 16;
  // state + protid + data + dvalid + crc + crc_valid
  localparam int unsigned FLIT_W   = STATE_W + PROTID_W + DATA_W + 1 + CRC_W + 1;

  // Field order (MSB first) matches {state, protid, data, dvalid, crc, crc_valid}.
  typedef struct packed {
    logic [STATE_W-1:0]  state;
    logic [PROTID_W-1:0] protid;
    logic [DATA_W-1:0]   data;
    logic                dvalid;
    logic [CRC_W-1:0]    crc;
    logic                crc_valid;
  } lpif_flit_t;

  typedef enum logic [STATE_W-1:0] {
    LpifStReset     = 4'h0,
    LpifStActive    = 4'h1,
    LpifStActPmNak  = 4'h3,
    LpifStL1        = 4'h4,
    LpifStL2        = 4'h8,
    LpifStLinkReset = 4'h9,
    LpifStLinkError = 4'hA,
    LpifStRetrain   = 4'hB,
    LpifStDisabled  = 4'hC
  } lpif_state_e;

  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  // a + b, clamped at 16'hFFFF.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? CNT16_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/lpif_ustrm_fifo.sv
// Synchronous DEPTH x FLIT_W FIFO holding upstream LPIF flits.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers only; storage is not reset)
//   clear         synchronous clear; wins over push and pop in the same cycle
//   push, wdata   write request and flit; ignored while full
//   pop           read request; ignored while empty
//   rdata         head flit (combinational read of the head entry)
//   full, empty   status flags
//   level         occupancy, 0..DEPTH
module lpif_ustrm_fifo
  import lpif_txrx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  lpif_flit_t        wdata,
  input  logic              pop,
  output lpif_flit_t        rdata,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   level
);

  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so that full (MSBs differ, index equal) and
  // empty (pointers equal) stay distinguishable after wrap.
  logic [AWIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0] rd_ptr_q, rd_ptr_d;
  logic            push_ok;
  logic            pop_ok;

  lpif_flit_t mem [DEPTH];

  always_comb begin
    full    = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
              (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    level   = wr_ptr_q - rd_ptr_q;
    push_ok = push && !full && !clear;
    pop_ok  = pop && !empty && !clear;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AWIDTH-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AWIDTH-1:0]];

endmodule

// File: rtl/lpif_ustrm_flit_buf.sv
// Upstream flit buffer between the LPIF adapter and the x16 full-rate TX packer.
// Accepts flits on a valid/ready handshake, buffers them in lpif_ustrm_fifo and
// replays them on registered ustrm_* outputs, one per cycle while link_up is high.
// Idle cycles hold the last state/protid/data/crc with all valid qualifiers low.
// Ports:
//   lclk, reset             clock, asynchronous active-high reset
//   flush                   synchronous discard of buffered flits (counted in drop_cnt)
//   link_up                 downstream ready; pops happen only while high
//   in_*                    flit fields from the adapter; in_valid/in_ready handshake
//   ustrm_*                 registered flit to the packer; ustrm_valid high on pop cycles + 1
//   fifo_level              current occupancy
//   drop_cnt                saturating count of flits discarded by flush
module lpif_ustrm_flit_buf
  import lpif_txrx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic                lclk,
  input  logic                reset,
  input  logic                flush,
  input  logic                link_up,
  input  logic [STATE_W-1:0]  in_state,
  input  logic [PROTID_W-1:0] in_protid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_dvalid,
  input  logic [CRC_W-1:0]    in_crc,
  input  logic                in_crc_valid,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [STATE_W-1:0]  ustrm_state,
  output logic [PROTID_W-1:0] ustrm_protid,
  output logic [DATA_W-1:0]   ustrm_data,
  output logic                ustrm_dvalid,
  output logic [CRC_W-1:0]    ustrm_crc,
  output logic                ustrm_crc_valid,
  output logic                ustrm_valid,
  output logic [AWIDTH:0]     fifo_level,
  output logic [15:0]         drop_cnt
);

  lpif_flit_t      in_flit;
  lpif_flit_t      head_flit;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AWIDTH:0] level;
  logic            push;
  logic            pop;

  lpif_flit_t      out_q, out_d;
  logic            valid_q, valid_d;
  logic [15:0]     drop_q, drop_d;
  logic [15:0]     drop_add;

  always_comb begin
    in_flit.state     = in_state;
    in_flit.protid    = in_protid;
    in_flit.data      = in_data;
    in_flit.dvalid    = in_dvalid;
    in_flit.crc       = in_crc;
    in_flit.crc_valid = in_crc_valid;
  end

  // Ready depends only on the registered fill state, never on a same-cycle pop,
  // so a full buffer refuses a push even when it is draining that cycle.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = link_up && !fifo_empty && !flush;

  lpif_ustrm_fifo #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_fifo (
    .clk   (lclk),
    .rst   (reset),
    .clear (flush),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .rdata (head_flit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Everything held at flush time plus a flit accepted in the flush cycle itself.
  assign drop_add = 16'(level) + 16'(push);

  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    drop_d  = drop_q;
    if (pop) begin
      out_d   = head_flit;
      valid_d = 1'b1;
    end else begin
      // Idle word: fields hold, qualifiers drop.
      out_d.dvalid    = 1'b0;
      out_d.crc_valid = 1'b0;
    end
    if (flush) drop_d = sat_add16(drop_q, drop_add);
  end

  always_ff @(posedge lclk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign ustrm_state     = out_q.state;
  assign ustrm_protid    = out_q.protid;
  assign ustrm_data      = out_q.data;
  assign ustrm_dvalid    = out_q.dvalid;
  assign ustrm_crc       = out_q.crc;
  assign ustrm_crc_valid = out_q.crc_valid;
  assign ustrm_valid     = valid_q;
  assign fifo_level      = level;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_lpif_ustrm_flit_buf.sv
module tb_lpif_ustrm_flit_buf;
  import lpif_txrx_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AWIDTH = $clog2(DEPTH);

  logic                lclk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic                link_up = 1'b0;
  logic                in_valid = 1'b0;
  lpif_flit_t          drv = '0;
  logic                in_ready;
  logic [STATE_W-1:0]  ustrm_state;
  logic [PROTID_W-1:0] ustrm_protid;
  logic [DATA_W-1:0]   ustrm_data;
  logic                ustrm_dvalid;
  logic [CRC_W-1:0]    ustrm_crc;
  logic                ustrm_crc_valid;
  logic                ustrm_valid;
  logic [AWIDTH:0]     fifo_level;
  logic [15:0]         drop_cnt;

  lpif_ustrm_flit_buf #(
    .DEPTH (DEPTH)
  ) dut (
    .lclk            (lclk),
    .reset           (reset),
    .flush           (flush),
    .link_up         (link_up),
    .in_state        (drv.state),
    .in_protid       (drv.protid),
    .in_data         (drv.data),
    .in_dvalid       (drv.dvalid),
    .in_crc          (drv.crc),
    .in_crc_valid    (drv.crc_valid),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .ustrm_state     (ustrm_state),
    .ustrm_protid    (ustrm_protid),
    .ustrm_data      (ustrm_data),
    .ustrm_dvalid    (ustrm_dvalid),
    .ustrm_crc       (ustrm_crc),
    .ustrm_crc_valid (ustrm_crc_valid),
    .ustrm_valid     (ustrm_valid),
    .fifo_level      (fifo_level),
    .drop_cnt        (drop_cnt)
  );

  always #5 lclk = ~lclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lpif_flit_t mk(input int i);
    lpif_flit_t f;
    f.state     = 4'(i);
    f.protid    = 2'(i);
    f.data      = {8{32'hC0DE0000 + 32'(i)}};
    f.dvalid    = 1'(i);
    f.crc       = 16'h1000 + 16'(i);
    f.crc_valid = ~1'(i);
    return f;
  endfunction

  // Reference model: a queue of accepted flits plus the word last shown downstream.
  lpif_flit_t  mq[$];
  lpif_flit_t  m_out = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_drop = '0;

  initial forever begin
    int          n;
    logic        pu;
    logic [16:0] s;
    @(posedge lclk or posedge reset);
    if (reset) begin
      mq.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_drop  = '0;
    end else begin
      n  = mq.size();
      pu = in_valid && (n < DEPTH);
      if (flush) begin
        s      = 17'(m_drop) + 17'(n) + 17'(pu);
        m_drop = (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
        mq.delete();
        m_valid         = 1'b0;
        m_out.dvalid    = 1'b0;
        m_out.crc_valid = 1'b0;
      end else begin
        if (link_up && n > 0) begin
          m_out   = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid         = 1'b0;
          m_out.dvalid    = 1'b0;
          m_out.crc_valid = 1'b0;
        end
        if (pu) mq.push_back(drv);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    lpif_flit_t got;
    @(negedge lclk);
    got.state     = ustrm_state;
    got.protid    = ustrm_protid;
    got.data      = ustrm_data;
    got.dvalid    = ustrm_dvalid;
    got.crc       = ustrm_crc;
    got.crc_valid = ustrm_crc_valid;
    check("m_flit", 320'(got), 320'(m_out));
    check("m_valid", 320'(ustrm_valid), 320'(m_valid));
    check("m_level", 320'(fifo_level), 320'(mq.size()));
    check("m_ready", 320'(in_ready), 320'(mq.size() < DEPTH));
    check("m_drop", 320'(drop_cnt), 320'(m_drop));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge lclk);
    #2;
  endtask

  initial begin
    lpif_flit_t f;
    int vcnt, first, last, maxlvl;

    repeat (3) @(posedge lclk);
    #2;
    check("rst_ready", 320'(in_ready), 320'd1);
    check("rst_level", 320'(fifo_level), 320'd0);
    check("rst_valid", 320'(ustrm_valid), 320'd0);
    reset = 1'b0;

    // Single flit: push, pop one cycle later, visible the cycle after that.
    link_up = 1'b1;
    f.state = 4'h3; f.protid = 2'h1; f.data = {32{8'hA5}};
    f.dvalid = 1'b1; f.crc = 16'hBEEF; f.crc_valid = 1'b1;
    drv = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge lclk);
    check("t1_level1", 320'(fifo_level), 320'd1);
    check("t1_notyet", 320'(ustrm_valid), 320'd0);
    @(negedge lclk);
    check("t1_valid", 320'(ustrm_valid), 320'd1);
    check("t1_data", 320'(ustrm_data), 320'({32{8'hA5}}));
    check("t1_state", 320'(ustrm_state), 320'h3);
    check("t1_crc", 320'(ustrm_crc), 320'hBEEF);
    check("t1_level0", 320'(fifo_level), 320'd0);

    // Fill with link down: 5 offered, 4 accepted, then drain in order.
    tick();
    link_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv = mk(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge lclk);
    check("t2_level4", 320'(fifo_level), 320'd4);
    check("t2_full", 320'(in_ready), 320'd0);
    tick();
    link_up = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(negedge lclk);
      if (ustrm_valid) begin
        f = mk(vcnt);
        check("t2_order", 320'(ustrm_data), 320'(f.data));
        vcnt++;
      end
    end
    check("t2_count", 320'(vcnt), 320'd4);
    check("t2_ready", 320'(in_ready), 320'd1);

    // Streaming: 20 flits back to back with the link up.
    tick();
    vcnt = 0; first = -1; last = -1; maxlvl = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          drv = mk(100 + i);
          in_valid = 1'b1;
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 24; k++) begin
          @(negedge lclk);
          if (ustrm_valid) begin
            if (first < 0) first = k;
            last = k;
            vcnt++;
          end
          if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
        end
      end
    join
    check("t3_count", 320'(vcnt), 320'd20);
    check("t3_nogap", 320'(last - first), 320'd19);
    check("t3_maxlvl", 320'(maxlvl <= 1), 320'd1);

    // Flush at level 3 with a push in the same cycle.
    tick();
    link_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv = mk(200 + i);
      in_valid = 1'b1;
      tick();
    end
    drv = mk(203);
    flush = 1'b1;
    link_up = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge lclk);
    check("t4_drop", 320'(drop_cnt), 320'd4);
    check("t4_level", 320'(fifo_level), 320'd0);
    check("t4_valid", 320'(ustrm_valid), 320'd0);

    // Idle hold after a flit with state 5.
    tick();
    drv = mk(5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge lclk);
    f = mk(5);
    check("t5_state", 320'(ustrm_state), 320'h5);
    check("t5_data", 320'(ustrm_data), 320'(f.data));
    check("t5_valid", 320'(ustrm_valid), 320'd0);
    check("t5_dvalid", 320'(ustrm_dvalid), 320'd0);
    check("t5_crcv", 320'(ustrm_crc_valid), 320'd0);

    // Reset in the middle of a cycle with two flits buffered.
    tick();
    link_up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv = mk(300 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge lclk);
    check("t6_level2", 320'(fifo_level), 320'd2);
    @(posedge lclk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_state", 320'(ustrm_state), 320'd0);
    check("t6_data", 320'(ustrm_data), 320'd0);
    check("t6_level", 320'(fifo_level), 320'd0);
    check("t6_ready", 320'(in_ready), 320'd1);
    check("t6_drop", 320'(drop_cnt), 320'd0);
    tick();
    reset = 1'b0;
    link_up = 1'b1;
    repeat (5) begin
      @(negedge lclk);
      check("t6_nostale", 320'(ustrm_valid), 320'd0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
